neuron_accumulator: RTL and testbench
=====================================

# neuron_accumulator

- Fixed-point multiply-accumulate stage directly upstream of the activation function.
- For one neuron it:
  - accepts a streamed sequence of (input, weight) pairs over a valid/ready handshake;
  - adds a per-neuron bias;
  - arithmetic-shifts and saturates the sum back to the shared Q_INT.Q_FRAC format;
  - presents the result with the neuron's activation mask for the activation function to consume.

## Interface

Parameters:
- MAX_LEN, 256: maximum terms per neuron; must satisfy MAX_LEN ≤ 2**ACC_GUARD.
- ACC_GUARD, 8: accumulator guard bits above the full product width.
- LEN_W, $clog2(MAX_LEN+1): width of `length`.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock.
  - reset  in  1  asynchronous, active-high reset.
- Per-neuron setup, sampled only in IDLE:
  - start  in  1  begins a neuron; ignored outside IDLE.
  - length  in  LEN_W  number of product terms, 0..MAX_LEN.
  - bias  in  Q_SIZE  signed Q_INT.Q_FRAC bias.
  - mask_in  in  ACT_MASK_SIZE  activation selector, carried through.
- Input stream:
  - in_valid  in  1  input pair valid.
  - in_ready  out  1  pair accepted when in_valid & in_ready.
  - in_x  in  Q_SIZE  signed activation input.
  - in_w  in  Q_SIZE  signed weight.
- Output stream:
  - out_valid  out  1  result valid.
  - out_ready  in  1  consumer ready.
  - out_x  out  Q_SIZE  saturated result.
  - out_mask  out  ACT_MASK_SIZE  mask latched at start.
  - out_sat  out  1  result was clipped.
- Status:
  - busy  out  1  state ≠ IDLE.

## Operation

States and transitions:
- IDLE
  - Goes to ACCUM on start.
  - Latches length and mask_in.
  - Loads acc ← sign-extended bias shifted left by Q_FRAC.
  - Sets count ← 0.
- ACCUM
  - in_ready = (count < length).
  - On each handshake: prod ← in_x*in_w (2·Q_SIZE, 2·Q_FRAC fraction bits), prod_valid ← 1, count++.
  - When prod_valid: acc ← acc + sign-extended prod.
  - Leaves for OUTPUT when count == length and !prod_valid. On that edge it registers out_x, out_sat and out_valid ← 1.
- OUTPUT
  - out_valid held with out_x, out_mask and out_sat stable until out_ready.
  - On the handshake, goes to IDLE.

Arithmetic rules:
- acc width is 2·Q_SIZE + ACC_GUARD.
- The result is acc arithmetically shifted right by Q_FRAC, truncating toward −∞.
- The result is then saturated to [−2^(Q_SIZE−1), 2^(Q_SIZE−1)−1] in LSB units.
- out_sat = 1 iff clipping occurred.

Boundary conditions:
- length = 0 → the result is the bias alone.
- start outside IDLE is ignored; it never corrupts the neuron in flight.
- in_valid while in_ready = 0 is not consumed.
- The cycle after the output handshake is IDLE; start is accepted there at earliest.
- reset at any point, including mid-ACCUM or OUTPUT, discards partial sums immediately and returns to IDLE.
- Reset values:
  - in_ready = 0, out_valid = 0, busy = 0;
  - out_x = 0, out_mask = 0, out_sat = 0;
  - acc = 0, count = 0, prod_valid = 0.

## Timing

- in_ready is registered-state driven only; it has no combinational path from in_valid.
- out_valid has no combinational dependence on out_ready.
- Throughput: one pair per cycle when in_valid stays high.
- Latency, length ≥ 1: last input handshake in cycle n → out_valid high in cycle n+3.
- Latency, length = 0: start in cycle s → out_valid in cycle s+2.
- Neuron-to-neuron overhead: 1 IDLE cycle plus pipeline drain.
- out_valid & out_ready in the same cycle → out_valid = 0 next cycle.

## Structure

- Shared definitions package:
  - Q_INT, Q_FRAC and Q_SIZE already exist there; ACT_MASK_SIZE is likewise taken from the package.
  - Add ACC_GUARD and a typedef for the state enum (IDLE, ACCUM, OUTPUT).
- One sub-module, `saturate_shift`:
  - combinational;
  - acc in, out_x and out_sat out;
  - reusable by later pooling stages.
- The multiplier stays inline as a registered product.

## Test plan

All values assume Q_INT = 8, Q_FRAC = 8.

1. Basic sum: length = 3, bias = 0x0080, three pairs x = 0x0100, w = 0x0200 → out_x = 0x0680, out_sat = 0, out_valid exactly 3 cycles after the third handshake.
2. Saturation:
   - length = 1, x = 0x4000, w = 0x0400 → out_x = 0x7FFF, out_sat = 1.
   - x = 0xC000 (−64.0), w = 0x0400 → out_x = 0x8000, out_sat = 1.
3. Truncation and length 0:
   - x = 0xFFFF, w = 0x0080, bias = 0 → out_x = 0xFFFF.
   - x = 0x0001 instead → out_x = 0x0000.
   - length = 0, bias = 0xFF00 → out_x = 0xFF00, out_valid at s+2.
4. Backpressure and gaps:
   - in_valid toggles every other cycle → same result as the contiguous stream.
   - out_ready low for 5 cycles → out_x and out_mask stable, in_ready = 0, start pulses ignored.
5. Reset mid-ACCUM after 2 of 4 pairs → all outputs at reset values. A following neuron (length = 1, x = 0x0100, w = 0x0100, bias = 0) → out_x = 0x0100, with no residue from the aborted neuron.
6. Back-to-back neurons with different mask_in values → each out_mask matches its own start; start held high continuously → exactly one neuron per IDLE visit.

Source files
------------

// File: rtl/neuron_accumulator_pkg.sv
// Shared fixed-point definitions for the neuron datapath: Q format, mask width,
// accumulator guard bits and the accumulator FSM state encoding.
package neuron_accumulator_pkg;

  localparam int Q_INT         = 8;
  localparam int Q_FRAC        = 8;
  localparam int Q_SIZE        = Q_INT + Q_FRAC;
  localparam int ACT_MASK_SIZE = 4;
  localparam int ACC_GUARD     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

endpackage

// File: rtl/saturate_shift.sv
// Combinational rescale of a wide accumulator back to Q_INT.Q_FRAC: floor shift
// by Q_FRAC, then clip to the signed Q_SIZE range and flag the clip.
module saturate_shift
  import neuron_accumulator_pkg::*;
#(
  parameter int ACC_W = 2 * Q_SIZE + ACC_GUARD
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [Q_SIZE-1:0] out_x_o,
  output logic              out_sat_o
);

  localparam int TOP = Q_FRAC + Q_SIZE - 1;

  logic [ACC_W-1:TOP] head_s;
  logic               unused_frac_s;

  assign head_s        = acc_i[ACC_W-1:TOP];
  assign unused_frac_s = ^acc_i[Q_FRAC-1:0];

  // Dropping the low bits of a two's-complement value is a floor; the result fits iff every bit from TOP up agrees
  always_comb begin
    out_x_o   = acc_i[TOP:Q_FRAC];
    out_sat_o = 1'b0;
    if ((&head_s) || !(|head_s)) begin
      out_x_o   = acc_i[TOP:Q_FRAC];
      out_sat_o = 1'b0;
    end else if (acc_i[ACC_W-1]) begin
      out_x_o   = {1'b1, {(Q_SIZE-1){1'b0}}};
      out_sat_o = 1'b1;
    end else begin
      out_x_o   = {1'b0, {(Q_SIZE-1){1'b1}}};
      out_sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Streams (x, w) pairs for one neuron through a registered multiplier into a guarded
// accumulator seeded with the bias, then hands the rescaled result to the activation stage.
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int MAX_LEN   = 256,
  parameter int ACC_GUARD = neuron_accumulator_pkg::ACC_GUARD,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         length,
  input  logic [Q_SIZE-1:0]        bias,
  input  logic [ACT_MASK_SIZE-1:0] mask_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Q_SIZE-1:0]        in_x,
  input  logic [Q_SIZE-1:0]        in_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Q_SIZE-1:0]        out_x,
  output logic [ACT_MASK_SIZE-1:0] out_mask,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int PROD_W = 2 * Q_SIZE;
  localparam int ACC_W  = PROD_W + ACC_GUARD;

  state_e                   state_q;
  logic [LEN_W-1:0]         length_q;
  logic [LEN_W-1:0]         count_q;
  logic [ACT_MASK_SIZE-1:0] mask_q;
  logic [ACC_W-1:0]         acc_q;
  logic [PROD_W-1:0]        prod_q;
  logic                     prod_valid_q;
  logic                     out_valid_q;
  logic [Q_SIZE-1:0]        out_x_q;
  logic [ACT_MASK_SIZE-1:0] out_mask_q;
  logic                     out_sat_q;

  logic                     in_hs_s;
  logic [ACC_W-1:0]         bias_ext_s;
  logic [ACC_W-1:0]         prod_ext_s;
  logic [PROD_W-1:0]        prod_d;
  logic [Q_SIZE-1:0]        sat_x_s;
  logic                     sat_s;

  assign in_ready   = (state_q == ACCUM) && (count_q < length_q);
  assign in_hs_s    = in_valid && in_ready;
  assign busy       = (state_q != IDLE);
  assign bias_ext_s = {{(ACC_W-Q_SIZE-Q_FRAC){bias[Q_SIZE-1]}}, bias, {Q_FRAC{1'b0}}};
  assign prod_ext_s = {{ACC_GUARD{prod_q[PROD_W-1]}}, prod_q};
  assign prod_d     = $signed({{Q_SIZE{in_x[Q_SIZE-1]}}, in_x})
                    * $signed({{Q_SIZE{in_w[Q_SIZE-1]}}, in_w});

  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_mask  = out_mask_q;
  assign out_sat   = out_sat_q;

  saturate_shift #(.ACC_W(ACC_W)) u_sat (
    .acc_i    (acc_q),
    .out_x_o  (sat_x_s),
    .out_sat_o(sat_s)
  );

  // Neuron FSM with the product pipeline, accumulator and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      length_q     <= '0;
      count_q      <= '0;
      mask_q       <= '0;
      acc_q        <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_mask_q   <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= ACCUM;
            length_q     <= length;
            mask_q       <= mask_in;
            acc_q        <= bias_ext_s;
            count_q      <= '0;
            prod_valid_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (in_hs_s) begin
            prod_q  <= prod_d;
            count_q <= count_q + LEN_W'(1);
          end
          prod_valid_q <= in_hs_s;
          if (prod_valid_q) begin
            acc_q <= acc_q + prod_ext_s;
          end
          // Leave only once the last product has drained into acc
          if ((count_q == length_q) && !prod_valid_q) begin
            state_q     <= OUTPUT;
            out_x_q     <= sat_x_s;
            out_sat_q   <= sat_s;
            out_mask_q  <= mask_q;
            out_valid_q <= 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: stimulus pushes expected results into a queue
// that an independent monitor pops on every output handshake.
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  length;
  logic [15:0] bias;
  logic [3:0]  mask_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_w;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [3:0]  out_mask;
  logic        out_sat;
  logic        busy;

  typedef struct {
    logic [15:0] x;
    logic [3:0]  m;
    logic        s;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs_cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = 0;

  neuron_accumulator dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .length   (length),
    .bias     (bias),
    .mask_in  (mask_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_w     (in_w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_mask (out_mask),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_valid && in_ready) last_hs_cyc = cyc;
  end

  // Monitor: every output handshake must match the oldest expected result
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected output x=%h mask=%h sat=%b, none required", out_x, out_mask, out_sat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_x !== e.x || out_mask !== e.m || out_sat !== e.s) begin
          errors++;
          $display("FAIL result: got x=%h mask=%h sat=%b, required x=%h mask=%h sat=%b",
                   out_x, out_mask, out_sat, e.x, e.m, e.s);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 200) begin
      tick();
      g++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy stuck at 1, required 0");
    end
  endtask

  task automatic start_neuron(input int len, input logic [15:0] b, input logic [3:0] m);
    wait_idle();
    start   = 1'b1;
    length  = 9'(len);
    bias    = b;
    mask_in = m;
    @(negedge clk);
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] xa[4], input logic [15:0] wa[4], input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      bit acc = 1'b0;
      int g = 0;
      in_valid = 1'b1;
      in_x     = xa[i];
      in_w     = wa[i];
      while (!acc && g < 100) begin
        @(negedge clk);
        acc = in_ready;
        tick();
        g++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL feed: pair %0d not accepted, in_ready=0 required 1", i);
      end
      in_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic wait_out();
    int g = 0;
    bit seen = 1'b0;
    while (!seen && g < 100) begin
      @(negedge clk);
      seen = out_valid;
      g++;
    end
    rise_cyc = cyc;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_out: out_valid never rose, required 1");
    end
  endtask

  task automatic push(input logic [15:0] x, input logic [3:0] m, input logic s);
    exp_t e;
    e.x = x;
    e.m = m;
    e.s = s;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [15:0] xa[4];
    logic [15:0] wa[4];
    int g;

    reset = 1'b1; start = 1'b0; length = '0; bias = '0; mask_in = '0;
    in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_x", 32'(out_x), 32'd0);
    check("rst_out_mask", 32'(out_mask), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Basic sum: 0.5 + 3 * (1.0 * 2.0) = 6.5
    xa = '{16'h0100, 16'h0100, 16'h0100, 16'h0000};
    wa = '{16'h0200, 16'h0200, 16'h0200, 16'h0000};
    push(16'h0680, 4'h1, 1'b0);
    start_neuron(3, 16'h0080, 4'h1);
    feed(xa, wa, 3, 1'b0);
    wait_out();
    check("latency_len3", 32'(rise_cyc - last_hs_cyc), 32'd3);

    // Saturation both ways
    xa = '{16'h4000, 16'h0, 16'h0, 16'h0};
    wa = '{16'h0400, 16'h0, 16'h0, 16'h0};
    push(16'h7FFF, 4'h2, 1'b1);
    start_neuron(1, 16'h0000, 4'h2);
    feed(xa, wa, 1, 1'b0);
    xa[0] = 16'hC000;
    push(16'h8000, 4'h3, 1'b1);
    start_neuron(1, 16'h0000, 4'h3);
    feed(xa, wa, 1, 1'b0);

    // Floor truncation
    xa[0] = 16'hFFFF;
    wa[0] = 16'h0080;
    push(16'hFFFF, 4'h4, 1'b0);
    start_neuron(1, 16'h0000, 4'h4);
    feed(xa, wa, 1, 1'b0);
    xa[0] = 16'h0001;
    push(16'h0000, 4'h5, 1'b0);
    start_neuron(1, 16'h0000, 4'h5);
    feed(xa, wa, 1, 1'b0);

    // Length zero: bias alone, out_valid two cycles after start
    push(16'hFF00, 4'h6, 1'b0);
    start_neuron(0, 16'hFF00, 4'h6);
    wait_out();
    check("latency_len0", 32'(rise_cyc - start_cyc), 32'd2);

    // Gapped input stream gives the contiguous result
    xa = '{16'h0100, 16'h0100, 16'h0100, 16'h0000};
    wa = '{16'h0200, 16'h0200, 16'h0200, 16'h0000};
    push(16'h0680, 4'h7, 1'b0);
    start_neuron(3, 16'h0080, 4'h7);
    feed(xa, wa, 3, 1'b1);

    // Output backpressure: held stable, no input accepted, start ignored
    wait_idle();
    out_ready = 1'b0;
    push(16'h0680, 4'h8, 1'b0);
    start_neuron(3, 16'h0080, 4'h8);
    feed(xa, wa, 3, 1'b0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      tick();
      start    = 1'(i % 2 == 0);
      length   = 9'd0;
      bias     = 16'h7FFF;
      mask_in  = 4'hF;
      in_valid = 1'b1;
      in_x     = 16'h1234;
      in_w     = 16'h1234;
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_x", 32'(out_x), 32'h0680);
      check("stall_out_mask", 32'(out_mask), 32'h8);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("post_hs_busy", 32'(busy), 32'd0);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);

    // Reset mid-ACCUM after 2 of 4 pairs, then a clean neuron
    xa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    wa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    start_neuron(4, 16'h0100, 4'h9);
    feed(xa, wa, 2, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_x", 32'(out_x), 32'd0);
    check("abort_out_mask", 32'(out_mask), 32'd0);
    check("abort_out_sat", 32'(out_sat), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    push(16'h0100, 4'hA, 1'b0);
    start_neuron(1, 16'h0000, 4'hA);
    feed(xa, wa, 1, 1'b0);

    // Back-to-back neurons with distinct masks
    push(16'h0100, 4'h3, 1'b0);
    start_neuron(1, 16'h0000, 4'h3);
    feed(xa, wa, 1, 1'b0);
    wa[0] = 16'h0300;
    push(16'h0300, 4'hC, 1'b0);
    start_neuron(1, 16'h0000, 4'hC);
    feed(xa, wa, 1, 1'b0);

    // start held for 30 cycles: length-0 neurons take 3 cycles each, so ten outputs
    wait_idle();
    for (int i = 0; i < 10; i++) push(16'h0123, 4'h5, 1'b0);
    start   = 1'b1;
    length  = 9'd0;
    bias    = 16'h0123;
    mask_in = 4'h5;
    repeat (30) tick();
    start = 1'b0;

    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    repeat (10) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
